sum_latch_uart_tx: RTL and testbench

- Parametrised operand adder with a result latch and a built-in UART transmitter; it is the next generation of the sum/latch/UART datapath behind the chip top.
- On a load strobe it adds two operands and latches the zero-extended sum.
- It then serialises the latched sum as SUM_W/8 UART frames, least-significant byte first.
- Frame options: optional parity and 1 or 2 stop bits.

---
 rtl/sum_latch_uart_tx.sv | 157 +++++++++++++++
 tb/tb_sum_latch_uart_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_latch_uart_tx.sv
// Operand adder with a result latch. An accepted load latches a_i + b_i and then sends
// the sum over a UART line as SUM_W/8 frames, least-significant byte first.
module sum_latch_uart_tx #(
    parameter int OPERAND_W = 8,
    parameter int SUM_W     = 16,
    parameter int CLK_DIV   = 104,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 load_i,
    input  logic [OPERAND_W-1:0] a_i,
    input  logic [OPERAND_W-1:0] b_i,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [SUM_W-1:0]     sum_o
);

    localparam int NBYTES = SUM_W / 8;
    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_baud;
    logic [2:0]          r_bit;
    logic [BYTE_W-1:0]   r_byte;
    logic [SUM_W-1:0]    r_sum;
    logic                r_tx;
    logic                r_busy;
    logic                r_done;

    logic [7:0]          w_byte;
    logic                w_bit_end;

    function automatic logic parity_bit(input logic [7:0] d);
        parity_bit = (PARITY == 2) ? ~(^d) : (^d);
    endfunction

    assign w_byte    = r_sum[{r_byte, 3'b000} +: 8];
    assign w_bit_end = (r_baud == BAUD_LAST);

    // r_bit counts data bits in DATA and stop bits in STOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_sum   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load_i && ena) begin
                        r_sum   <= SUM_W'(a_i) + SUM_W'(b_i);
                        r_busy  <= 1'b1;
                        r_tx    <= 1'b0;
                        r_byte  <= '0;
                        r_bit   <= '0;
                        r_baud  <= '0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= w_byte[0];
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_bit <= '0;
                            if (PARITY != 0) begin
                                r_tx    <= parity_bit(w_byte);
                                r_state <= S_PAR;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_tx  <= w_byte[r_bit + 3'd1];
                        end
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end
                S_PAR: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit == STOP_LAST) begin
                            r_bit <= '0;
                            if (r_byte == BYTE_LAST) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_byte  <= r_byte + BYTE_W'(1);
                                r_tx    <= 1'b0;
                                r_state <= S_START;
                            end
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_o   = r_tx;
    assign busy_o = r_busy;
    assign done_o = r_done;
    assign sum_o  = r_sum;

endmodule

// File: tb/tb_sum_latch_uart_tx.sv
// Bench for sum_latch_uart_tx: four configurations run side by side against a cycle-level
// model derived from the frame format, plus hand-computed literal checks.
module tb_sum_latch_uart_tx;

    localparam int CD = 4;
    localparam int PARV [4] = '{0, 1, 2, 0};
    localparam int SBV  [4] = '{1, 1, 1, 2};
    localparam int NBV  [4] = '{2, 2, 2, 3};

    logic        clk;
    logic        rst_n;
    logic        ld   [4];
    logic        en   [4];
    logic [7:0]  a    [4];
    logic [7:0]  b    [4];
    logic        dtx  [4];
    logic        dbusy[4];
    logic        ddone[4];
    logic [15:0] s0, s1, s2;
    logic [23:0] s3;
    logic [31:0] dsum [4];

    int checks = 0;
    int errors = 0;

    // model state
    logic        m_busy[4];
    logic        m_done[4];
    logic [31:0] m_sum [4];
    int          m_t   [4];
    logic        hist  [4][512];
    int          dcnt  [4];

    assign dsum[0] = 32'(s0);
    assign dsum[1] = 32'(s1);
    assign dsum[2] = 32'(s2);
    assign dsum[3] = 32'(s3);

    sum_latch_uart_tx #(.OPERAND_W(8), .SUM_W(16), .CLK_DIV(CD), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .ena(en[0]), .load_i(ld[0]), .a_i(a[0]), .b_i(b[0]),
        .tx_o(dtx[0]), .busy_o(dbusy[0]), .done_o(ddone[0]), .sum_o(s0));
    sum_latch_uart_tx #(.OPERAND_W(8), .SUM_W(16), .CLK_DIV(CD), .PARITY(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .ena(en[1]), .load_i(ld[1]), .a_i(a[1]), .b_i(b[1]),
        .tx_o(dtx[1]), .busy_o(dbusy[1]), .done_o(ddone[1]), .sum_o(s1));
    sum_latch_uart_tx #(.OPERAND_W(8), .SUM_W(16), .CLK_DIV(CD), .PARITY(2), .STOP_BITS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .ena(en[2]), .load_i(ld[2]), .a_i(a[2]), .b_i(b[2]),
        .tx_o(dtx[2]), .busy_o(dbusy[2]), .done_o(ddone[2]), .sum_o(s2));
    sum_latch_uart_tx #(.OPERAND_W(8), .SUM_W(24), .CLK_DIV(CD), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst_n(rst_n), .ena(en[3]), .load_i(ld[3]), .a_i(a[3]), .b_i(b[3]),
        .tx_o(dtx[3]), .busy_o(dbusy[3]), .done_o(ddone[3]), .sum_o(s3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int frame_len(input int i);
        return (10 + ((PARV[i] != 0) ? 1 : 0) + (SBV[i] - 1)) * CD;
    endfunction

    // Expected line level t cycles after the accept edge, straight from the frame layout.
    function automatic logic exp_wave(input int i, input int t);
        int         f, p;
        logic [7:0] byt;
        logic [31:0] sh;
        f   = t / frame_len(i);
        p   = (t % frame_len(i)) / CD;
        sh  = m_sum[i] >> (8 * f);
        byt = sh[7:0];
        if (p == 0) return 1'b0;
        if (p <= 8) return byt[p-1];
        if (PARV[i] != 0 && p == 9) return (PARV[i] == 1) ? ^byt : ~(^byt);
        return 1'b1;
    endfunction

    function automatic logic [7:0] dec_byte(input int i, input int f);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = hist[i][f * frame_len(i) + (1 + k) * CD + CD / 2];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
                m_sum[i]  <= '0;
                m_t[i]    <= 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_done[i] <= 1'b0;
                if (m_busy[i]) begin
                    m_t[i] <= m_t[i] + 1;
                    if (m_t[i] + 1 == NBV[i] * frame_len(i)) begin
                        m_busy[i] <= 1'b0;
                        m_done[i] <= 1'b1;
                    end
                end else if (ld[i] && en[i]) begin
                    m_sum[i]  <= 32'(a[i]) + 32'(b[i]);
                    m_busy[i] <= 1'b1;
                    m_t[i]    <= 0;
                end
            end
        end
    end

    initial for (int i = 0; i < 4; i++) dcnt[i] = 0;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (m_busy[i] && m_t[i] < 512) hist[i][m_t[i]] <= dtx[i];
            if (ddone[i] === 1'b1) dcnt[i] <= dcnt[i] + 1;
            chk($sformatf("tx%0d", i), longint'(dtx[i]), longint'(m_busy[i] ? exp_wave(i, m_t[i]) : 1'b1));
            chk($sformatf("busy%0d", i), longint'(dbusy[i]), longint'(m_busy[i]));
            chk($sformatf("done%0d", i), longint'(ddone[i]), longint'(m_done[i]));
            chk($sformatf("sum%0d", i), longint'(dsum[i]), longint'(m_sum[i]));
        end
    end

    int d_edge[4];
    int edges;
    int base;
    bit ok;

    initial begin
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ld[i] = 1'b0; en[i] = 1'b1; a[i] = '0; b[i] = '0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", longint'(dtx[0]), 1);
        chk("rst_busy", longint'(dbusy[0]), 0);
        chk("rst_done", longint'(ddone[0]), 0);
        chk("rst_sum", longint'(s0), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Phase 1: one transaction per configuration, ignored load mid-busy on u0
        a[0] = 8'hFF; b[0] = 8'h01;
        a[1] = 8'h03; b[1] = 8'h04;
        a[2] = 8'h03; b[2] = 8'h04;
        a[3] = 8'h80; b[3] = 8'h80;
        for (int i = 0; i < 4; i++) begin ld[i] = 1'b1; d_edge[i] = -1; end
        base = dcnt[0];
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) ld[i] = 1'b0;
        edges = 0;
        ok = 1'b0;
        while (edges < 200 && !ok) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 10) begin ld[0] = 1'b1; a[0] = 8'h10; b[0] = 8'h20; end
            if (edges == 12) ld[0] = 1'b0;
            for (int i = 0; i < 4; i++) if (ddone[i] && d_edge[i] < 0) d_edge[i] = edges;
            if (!dbusy[0] && !dbusy[1] && !dbusy[2] && !dbusy[3]) ok = 1'b1;
        end
        chk("p1_timeout", longint'(ok), 1);
        chk("lat_u0", d_edge[0], 80);
        chk("lat_u1", d_edge[1], 88);
        chk("lat_u3", d_edge[3], 132);
        chk("sum_u0", longint'(s0), 16'h0100);
        chk("sum_u1", longint'(s1), 16'h0007);
        chk("sum_u3", longint'(s3), 24'h000100);
        chk("u0_byte0", longint'(dec_byte(0, 0)), 8'h00);
        chk("u0_byte1", longint'(dec_byte(0, 1)), 8'h01);
        chk("u0_start", longint'(hist[0][2]), 0);
        chk("u0_stop", longint'(hist[0][9 * CD + 2]), 1);
        chk("u1_even_par", longint'(hist[1][9 * CD + 2]), 1);
        chk("u2_odd_par", longint'(hist[2][9 * CD + 2]), 0);
        chk("u3_byte0", longint'(dec_byte(3, 0)), 8'h00);
        chk("u3_byte1", longint'(dec_byte(3, 1)), 8'h01);
        chk("u3_byte2", longint'(dec_byte(3, 2)), 8'h00);
        chk("u3_stop2", longint'(hist[3][10 * CD + 2]), 1);
        chk("u0_done_cnt", dcnt[0] - base, 1);

        // Phase 2: load with ena low is ignored
        @(negedge clk);
        en[0] = 1'b0; ld[0] = 1'b1; a[0] = 8'h10; b[0] = 8'h20;
        repeat (3) @(negedge clk);
        chk("ena0_busy", longint'(dbusy[0]), 0);
        chk("ena0_sum", longint'(s0), 16'h0100);
        ld[0] = 1'b0; en[0] = 1'b1;

        // Phase 3: load held high gives back-to-back transmissions
        a[0] = 8'h05; b[0] = 8'h06; ld[0] = 1'b1;
        for (int r = 0; r < 2; r++) begin
            ok = 1'b0;
            for (int c = 0; c < 200 && !ok; c++) begin
                @(posedge clk); #1;
                if (ddone[0]) ok = 1'b1;
            end
            chk("b2b_timeout", longint'(ok), 1);
            chk("b2b_gap_busy", longint'(dbusy[0]), 0);
            chk("b2b_gap_tx", longint'(dtx[0]), 1);
            @(posedge clk); #1;
            chk("b2b_re_busy", longint'(dbusy[0]), 1);
            chk("b2b_re_tx", longint'(dtx[0]), 0);
            chk("b2b_sum", longint'(s0), 16'h000B);
        end
        ld[0] = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(posedge clk); #1;
            if (ddone[0]) ok = 1'b1;
        end
        chk("drain_timeout", longint'(ok), 1);

        // Phase 4: reset mid-frame
        @(negedge clk);
        a[0] = 8'h01; b[0] = 8'h02; ld[0] = 1'b1;
        @(posedge clk); #1;
        ld[0] = 1'b0;
        repeat (30) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_tx", longint'(dtx[0]), 1);
        chk("abort_busy", longint'(dbusy[0]), 0);
        chk("abort_sum", longint'(s0), 0);
        base = dcnt[0];
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("abort_no_done", dcnt[0] - base, 0);
        chk("abort_idle_tx", longint'(dtx[0]), 1);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
